// File: rtl/router_pkt_tx_if.sv
// Bundle of the payload-write, command and router-facing frame signals of
// router_pkt_tx. The master modport is the packet source itself; the slave
// modport is whatever feeds it bytes/commands and consumes the frame.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready never depends on cmd_valid. A transferred
// command is either started (header next cycle) or rejected (cmd_err next
// cycle); a command that sees cmd_ready low is simply not taken.
interface router_pkt_tx_if #(
    parameter int DEPTH = 16
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // payload write side
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             wr_drop;

    // command side
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_dest;
    logic [3:0]       cmd_len;
    logic             cmd_bad_par;
    logic             cmd_err;

    // router side
    logic             rtr_busy;
    logic             pkt_valid;
    logic [7:0]       pkt_data;
    logic             tx_done;

    // FSM state for checkers (IDLE=0, HDR=1, DATA=2, PAR=3)
    logic [1:0]       dbg_state;

    modport master (
        input  wr_en, wr_data, cmd_valid, cmd_dest, cmd_len, cmd_bad_par, rtr_busy,
        output fifo_full, fifo_count, wr_drop, cmd_ready, cmd_err,
               pkt_valid, pkt_data, tx_done, dbg_state
    );

    modport slave (
        output wr_en, wr_data, cmd_valid, cmd_dest, cmd_len, cmd_bad_par, rtr_busy,
        input  fifo_full, fifo_count, wr_drop, cmd_ready, cmd_err,
               pkt_valid, pkt_data, tx_done, dbg_state
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for one router input port. Payload bytes are buffered in a
// circular FIFO; an accepted command emits header, LEN payload bytes and an
// XOR parity byte as one unbroken pkt_valid burst, then holds off new
// commands for GAP cycles.
module router_pkt_tx #(
    parameter int DEPTH = 16,
    parameter int GAP   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    router_pkt_tx_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_PAR  = 2'd3
    } state_e;

    // state and datapath registers
    state_e          state_q,     state_d;
    logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [AW:0]     count_q,     count_d;
    logic [GW-1:0]   gap_q,       gap_d;
    logic [3:0]      len_q,       len_d;
    logic [3:0]      sent_q,      sent_d;
    logic            bad_par_q,   bad_par_d;
    logic [7:0]      par_q,       par_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic [7:0]      pkt_data_q,  pkt_data_d;
    logic            tx_done_q,   tx_done_d;
    logic            cmd_err_q,   cmd_err_d;
    logic            wr_drop_q,   wr_drop_d;

    logic [7:0]      mem_q [DEPTH];

    // combinational helpers
    logic            full;
    logic            pop;
    logic            push;
    logic            cmd_ready;
    logic            cmd_take;
    logic            cmd_reject;
    logic [AW:0]     len_ext;
    logic [7:0]      header;
    logic [7:0]      head_byte;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign head_byte = mem_q[rd_ptr_q];
    assign header    = {2'b00, bus.cmd_len, bus.cmd_dest};
    assign len_ext   = (AW+1)'(bus.cmd_len);

    // A byte leaves the FIFO on every edge that advances the frame to the
    // next payload byte: leaving HDR, and inside DATA until LEN bytes are out.
    assign pop  = (state_q == S_HDR) || ((state_q == S_DATA) && (sent_q != len_q));

    // A full FIFO still takes a byte when a pop frees a slot on the same edge.
    assign push = bus.wr_en && (!full || pop);

    // Ready is held low in reset so nothing can transfer while resetn is low.
    assign cmd_ready  = resetn && (state_q == S_IDLE) && (gap_q == '0) && !bus.rtr_busy;
    assign cmd_take   = bus.cmd_valid && cmd_ready;
    assign cmd_reject = (bus.cmd_len == 4'd0) || (bus.cmd_dest == 2'b11) ||
                        (len_ext > count_q);

    // Next-state, FIFO pointer and registered-output computation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        gap_d       = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        len_d       = len_q;
        sent_d      = sent_q;
        bad_par_d   = bad_par_q;
        par_d       = par_q;
        pkt_valid_d = pkt_valid_q;
        pkt_data_d  = pkt_data_q;
        tx_done_d   = 1'b0;
        cmd_err_d   = 1'b0;
        wr_drop_d   = bus.wr_en && full && !pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_take) begin
                    if (cmd_reject) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d     = S_HDR;
                        len_d       = bus.cmd_len;
                        bad_par_d   = bus.cmd_bad_par;
                        par_d       = header;
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = header;
                    end
                end
            end
            S_HDR: begin
                state_d    = S_DATA;
                pkt_data_d = head_byte;
                par_d      = par_q ^ head_byte;
                sent_d     = 4'd1;
            end
            S_DATA: begin
                if (sent_q == len_q) begin
                    state_d    = S_PAR;
                    pkt_data_d = par_q ^ {8{bad_par_q}};
                end else begin
                    pkt_data_d = head_byte;
                    par_d      = par_q ^ head_byte;
                    sent_d     = sent_q + 4'd1;
                end
            end
            S_PAR: begin
                state_d     = S_IDLE;
                pkt_valid_d = 1'b0;
                pkt_data_d  = 8'h00;
                tx_done_d   = 1'b1;
                gap_d       = GW'(GAP);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; synchronous active-low reset flushes the FIFO and
    // abandons any frame in flight without a tx_done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            len_q       <= 4'd0;
            sent_q      <= 4'd0;
            bad_par_q   <= 1'b0;
            par_q       <= 8'h00;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= 8'h00;
            tx_done_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            sent_q      <= sent_d;
            bad_par_q   <= bad_par_d;
            par_q       <= par_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            tx_done_q   <= tx_done_d;
            cmd_err_q   <= cmd_err_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // Payload storage write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.fifo_full  = full;
    assign bus.fifo_count = count_q;
    assign bus.wr_drop    = wr_drop_q;
    assign bus.cmd_ready  = cmd_ready;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.pkt_data   = pkt_data_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: a per-cycle vector table for the basic
// frame/reject/busy/gap behaviour, then hand sequences for FIFO fill and wrap
// and for reset in the middle of a frame.
module tb_router_pkt_tx;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    router_pkt_tx_if #(.DEPTH(16)) bif ();

    router_pkt_tx #(.DEPTH(16), .GAP(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif.master)
    );

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       cmd_valid;
        logic [1:0] dest;
        logic [3:0] len;
        logic       bad;
        logic       busy;
        logic       e_rdy;
        logic       e_pv;
        logic [7:0] e_pd;
        logic       e_done;
        logic       e_err;
        logic       e_drop;
        logic [4:0] e_cnt;
        logic       e_full;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic void v(input int rst, input int wr, input int wd, input int cv,
                              input int dest, input int len, input int bad, input int busy,
                              input int rdy, input int pv, input int pd, input int done,
                              input int err, input int drop, input int cnt, input int full);
        vec_t t;
        t.rst_n = 1'(rst);  t.wr_en = 1'(wr);    t.wr_data = 8'(wd);  t.cmd_valid = 1'(cv);
        t.dest  = 2'(dest); t.len   = 4'(len);   t.bad     = 1'(bad); t.busy      = 1'(busy);
        t.e_rdy = 1'(rdy);  t.e_pv  = 1'(pv);    t.e_pd    = 8'(pd);  t.e_done    = 1'(done);
        t.e_err = 1'(err);  t.e_drop = 1'(drop); t.e_cnt   = 5'(cnt); t.e_full    = 1'(full);
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bif.wr_en       = 1'b0;
        bif.wr_data     = 8'h00;
        bif.cmd_valid   = 1'b0;
        bif.cmd_dest    = 2'd0;
        bif.cmd_len     = 4'd0;
        bif.cmd_bad_par = 1'b0;
        bif.rtr_busy    = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        drive_idle();
        bif.wr_en   = 1'b1;
        bif.wr_data = b;
        exp_q.push_back(b);
    endtask

    // Present a command and hold it until ready, within a bounded wait.
    task automatic send_cmd(input logic [1:0] dest, input logic [3:0] len, input logic bad);
        int waited;
        waited = 0;
        @(negedge clk);
        drive_idle();
        bif.cmd_valid   = 1'b1;
        bif.cmd_dest    = dest;
        bif.cmd_len     = len;
        bif.cmd_bad_par = bad;
        #1;
        while (bif.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("cmd_accept_wait", 32'(bif.cmd_ready), 1);
    endtask

    // Header cycle, optionally pushing a byte into the FIFO during it.
    task automatic expect_hdr(input logic [7:0] hdr, input logic do_push, input logic [7:0] pb);
        @(negedge clk);
        drive_idle();
        if (do_push) begin
            bif.wr_en   = 1'b1;
            bif.wr_data = pb;
        end
        #1;
        chk("hdr_valid", 32'(bif.pkt_valid), 1);
        chk("hdr_byte", 32'(bif.pkt_data), 32'(hdr));
        chk("hdr_state", 32'(bif.dbg_state), 1);
        if (do_push) exp_q.push_back(pb);
    endtask

    // Payload bytes in FIFO order, then parity, then the tx_done cycle.
    task automatic expect_body(input int len, input logic [7:0] hdr, input logic bad);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            par = par ^ b;
            chk("data_valid", 32'(bif.pkt_valid), 1);
            chk("data_byte", 32'(bif.pkt_data), 32'(b));
            chk("data_count", 32'(bif.fifo_count), 32'(exp_q.size()));
            chk("data_no_drop", 32'(bif.wr_drop), 0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("par_valid", 32'(bif.pkt_valid), 1);
        chk("par_byte", 32'(bif.pkt_data), 32'(bad ? ~par : par));
        @(negedge clk);
        #1;
        chk("done_pulse", 32'(bif.tx_done), 1);
        chk("done_idle", 32'(bif.pkt_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        // rst wr  wd  cv dst len bad busy | rdy pv pd  done err drop cnt full
        v(0, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        // basic frame: dest 1, three bytes
        v(1, 1, 8'h11, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(1, 1, 8'h22, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 1, 0);
        v(1, 1, 8'h33, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 1, 1, 3, 0, 0,   1, 0, 8'h00, 0, 0, 0, 3, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h0D, 0, 0, 0, 3, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h11, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h22, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h33, 0, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h0D, 0, 0, 0, 0, 0); // 0D^11^22^33
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        // inverted parity: dest 2, AA 55
        v(1, 1, 8'hAA, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(1, 1, 8'h55, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 1, 2, 2, 1, 0,   1, 0, 8'h00, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h0A, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'hAA, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h55, 0, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h0A, 0, 0, 0, 0, 0); // ~(0A^AA^55)
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        // rejects with two bytes buffered
        v(1, 1, 8'h01, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0, 0);
        v(1, 1, 8'h02, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 1, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 2, 0); // len 0
        v(1, 0, 8'h00, 1, 3, 1, 0, 0,   1, 0, 8'h00, 0, 1, 0, 2, 0); // dest 3
        v(1, 0, 8'h00, 1, 0, 4, 0, 0,   1, 0, 8'h00, 0, 1, 0, 2, 0); // len > count
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 1, 0, 2, 0);
        // router busy holds off acceptance; header one cycle after busy drops
        v(1, 0, 8'h00, 1, 0, 2, 0, 1,   0, 0, 8'h00, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 1, 0, 2, 0, 1,   0, 0, 8'h00, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 1, 0, 2, 0, 0,   1, 0, 8'h00, 0, 0, 0, 2, 0);
        // next command held through the frame and gap; push during a pop
        v(1, 1, 8'h5A, 1, 1, 1, 0, 0,   0, 1, 8'h08, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 1, 1, 1, 0, 1,   0, 1, 8'h01, 0, 0, 0, 2, 0);
        v(1, 0, 8'h00, 1, 1, 1, 0, 0,   0, 1, 8'h02, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 1, 1, 1, 0, 0,   0, 1, 8'h0B, 0, 0, 0, 1, 0); // 08^01^02
        v(1, 0, 8'h00, 1, 1, 1, 0, 0,   0, 0, 8'h00, 1, 0, 0, 1, 0);
        v(1, 0, 8'h00, 1, 1, 1, 0, 0,   0, 0, 8'h00, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 1, 1, 1, 0, 0,   1, 0, 8'h00, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h05, 0, 0, 0, 1, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h5A, 0, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h5F, 0, 0, 0, 0, 0); // 05^5A
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0, 0);
        v(1, 0, 8'h00, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0, 0);

        // clock/reset
        resetn = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            resetn          = vecs[i].rst_n;
            bif.wr_en       = vecs[i].wr_en;
            bif.wr_data     = vecs[i].wr_data;
            bif.cmd_valid   = vecs[i].cmd_valid;
            bif.cmd_dest    = vecs[i].dest;
            bif.cmd_len     = vecs[i].len;
            bif.cmd_bad_par = vecs[i].bad;
            bif.rtr_busy    = vecs[i].busy;
            #1;
            n_vec++;
            if (bif.cmd_ready !== vecs[i].e_rdy || bif.pkt_valid !== vecs[i].e_pv ||
                bif.pkt_data !== vecs[i].e_pd || bif.tx_done !== vecs[i].e_done ||
                bif.cmd_err !== vecs[i].e_err || bif.wr_drop !== vecs[i].e_drop ||
                bif.fifo_count !== vecs[i].e_cnt || bif.fifo_full !== vecs[i].e_full) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy=%b pv=%b pd=%h done=%b err=%b drop=%b cnt=%0d full=%b, expected rdy=%b pv=%b pd=%h done=%b err=%b drop=%b cnt=%0d full=%b",
                         i, bif.cmd_ready, bif.pkt_valid, bif.pkt_data, bif.tx_done, bif.cmd_err,
                         bif.wr_drop, bif.fifo_count, bif.fifo_full,
                         vecs[i].e_rdy, vecs[i].e_pv, vecs[i].e_pd, vecs[i].e_done, vecs[i].e_err,
                         vecs[i].e_drop, vecs[i].e_cnt, vecs[i].e_full);
            end
        end

        // fill to full, overflow drop, then two max-length frames across the wrap
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        @(negedge clk);
        drive_idle();
        bif.wr_en   = 1'b1;
        bif.wr_data = 8'hEE;
        #1;
        chk("full_after_16", 32'(bif.fifo_full), 1);
        chk("count_16", 32'(bif.fifo_count), 16);
        @(negedge clk);
        drive_idle();
        #1;
        chk("drop_pulse", 32'(bif.wr_drop), 1);
        chk("count_after_drop", 32'(bif.fifo_count), 16);
        @(negedge clk);
        #1;
        chk("drop_single_cycle", 32'(bif.wr_drop), 0);

        send_cmd(2'd0, 4'd15, 1'b0);
        expect_hdr(8'h3C, 1'b1, 8'h77);
        expect_body(15, 8'h3C, 1'b0);

        for (int i = 0; i < 13; i++) push_byte(8'(8'h80 + i));
        send_cmd(2'd2, 4'd15, 1'b0);
        chk("count_15", 32'(bif.fifo_count), 15);
        expect_hdr(8'h3E, 1'b0, 8'h00);
        expect_body(15, 8'h3E, 1'b0);
        chk("fifo_drained", 32'(bif.fifo_count), 0);

        // reset while in the payload phase
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        send_cmd(2'd0, 4'd3, 1'b0);
        expect_hdr(8'h0C, 1'b0, 8'h00);
        @(negedge clk);
        drive_idle();
        #1;
        b = exp_q.pop_front();
        chk("pre_reset_byte", 32'(bif.pkt_data), 32'(b));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        b = exp_q.pop_front();
        chk("reset_cycle_byte", 32'(bif.pkt_data), 32'(b));
        chk("reset_cycle_valid", 32'(bif.pkt_valid), 1);
        @(negedge clk);
        #1;
        chk("rst_valid_low", 32'(bif.pkt_valid), 0);
        chk("rst_data_zero", 32'(bif.pkt_data), 0);
        chk("rst_fifo_flushed", 32'(bif.fifo_count), 0);
        chk("rst_ready_low", 32'(bif.cmd_ready), 0);
        chk("rst_state_idle", 32'(bif.dbg_state), 0);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        #1;
        chk("post_rst_ready", 32'(bif.cmd_ready), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_rst", 32'(bif.tx_done), 0);
            chk("no_valid_after_rst", 32'(bif.pkt_valid), 0);
        end
        chk("post_rst_count", 32'(bif.fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
